// File: rtl/debouncer_multicanal.sv
// N-channel push-button debouncer sharing one sample-tick prescaler.
// Optional long-press detection enabled by defining DEBOUNCER_MANTENIDO_EN.
module debouncer_multicanal #(
    parameter int CANALES    = 4,
    parameter int DIV_CUENTA = 75000,
    parameter int MUESTRAS   = 4,
    parameter int LARGO      = 200
) (
    input  logic               reloja,
    input  logic               reset_n,
    input  logic [CANALES-1:0] entrada,
    output logic [CANALES-1:0] arebote,
    output logic [CANALES-1:0] subida,
    output logic [CANALES-1:0] bajada,
    output logic               tick,
    output logic [CANALES-1:0] mantenido
);

    localparam int PW = $clog2(DIV_CUENTA);
    localparam int CW = $clog2(MUESTRAS + 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(DIV_CUENTA - 1);
    localparam logic [CW-1:0] CONT_MAX = CW'(MUESTRAS - 1);

    logic [PW-1:0]      pre;
    logic [CANALES-1:0] meta;
    logic [CANALES-1:0] sinc;
    logic [CW-1:0]      cont [CANALES];

    assign tick = (pre == PRE_MAX);

    always_ff @(posedge reloja or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Two-flop synchroniser, then per-channel qualification on each tick.
    always_ff @(posedge reloja or negedge reset_n) begin
        if (!reset_n) begin
            meta    <= '0;
            sinc    <= '0;
            arebote <= '0;
            subida  <= '0;
            bajada  <= '0;
            for (int i = 0; i < CANALES; i++) begin
                cont[i] <= '0;
            end
        end else begin
            meta   <= entrada;
            sinc   <= meta;
            subida <= '0;
            bajada <= '0;
            if (tick) begin
                for (int i = 0; i < CANALES; i++) begin
                    if (sinc[i] == arebote[i]) begin
                        cont[i] <= '0;
                    end else if (cont[i] == CONT_MAX) begin
                        arebote[i] <= sinc[i];
                        subida[i]  <= sinc[i];
                        bajada[i]  <= ~sinc[i];
                        cont[i]    <= '0;
                    end else begin
                        cont[i] <= cont[i] + CW'(1);
                    end
                end
            end
        end
    end

`ifdef DEBOUNCER_MANTENIDO_EN
    localparam int HW = $clog2(LARGO + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LARGO);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LARGO - 1);

    logic [HW-1:0] hold [CANALES];

    // Saturating hold counter gives exactly one pulse per press.
    always_ff @(posedge reloja or negedge reset_n) begin
        if (!reset_n) begin
            mantenido <= '0;
            for (int i = 0; i < CANALES; i++) begin
                hold[i] <= '0;
            end
        end else begin
            mantenido <= '0;
            for (int i = 0; i < CANALES; i++) begin
                if (!arebote[i]) begin
                    hold[i] <= '0;
                end else if (tick && hold[i] != HOLD_MAX) begin
                    hold[i] <= hold[i] + HW'(1);
                    if (hold[i] == HOLD_PRE) begin
                        mantenido[i] <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign mantenido = '0;
`endif

endmodule
